masked_act_pipe: RTL and testbench

Pipelined, multi-lane masked activation unit for the garbled-inference datapath. Each lane takes a masked value from the evaluator and a mask pair from the garbler. It unmasks the value and emits a re-masked activation.

---
 rtl/masked_pkg.sv | 24 ++
 rtl/masked_act_lane.sv | 29 ++
 rtl/masked_act_pipe.sv | 121 ++++++++++++
 tb/tb_masked_act_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/masked_pkg.sv
// Shared definitions for the masked activation datapath: mode encoding and
// lane-slice offsets for the evaluator word and garbler mask-pair buses.
package masked_pkg;

  typedef enum logic {
    MODE_SIGN = 1'b0,
    MODE_RELU = 1'b1
  } mode_e;

  // Bit offset of lane's masked input word on e_input / o.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // Mask pairs are interleaved per lane: mask1 then mask2.
  function automatic int unsigned mask1_lsb(input int unsigned lane, input int unsigned width);
    return 2 * lane * width;
  endfunction

  function automatic int unsigned mask2_lsb(input int unsigned lane, input int unsigned width);
    return 2 * lane * width + width;
  endfunction

endpackage

// File: rtl/masked_act_lane.sv
// Single-lane second-stage function: unmasked value and output mask to the
// re-masked SIGN or RELU activation, plus the lane's positive flag.
module masked_act_lane
  import masked_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] mask2,
  input  mode_e            mode,
  output logic [WIDTH-1:0] o_c,
  output logic             pos_c
);

  logic neg;
  assign neg = u[WIDTH-1];

  // Zero has sign bit 0 and therefore takes the positive branch.
  always_comb begin
    o_c   = mask2;
    pos_c = !neg;
    unique case (mode)
      MODE_SIGN: o_c = neg ? (mask2 - WIDTH'(1)) : (mask2 + WIDTH'(1));
      MODE_RELU: o_c = neg ? mask2 : (u + mask2);
      default:   o_c = mask2;
    endcase
  end

endmodule

// File: rtl/masked_act_pipe.sv
// Two-stage, multi-lane masked activation pipeline with valid/ready
// backpressure, per-beat positive-lane count and accepted-beat counter.
module masked_act_pipe
  import masked_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [LANES*WIDTH-1:0]       e_input,
  input  logic [2*LANES*WIDTH-1:0]     g_input,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       o,
  output logic [$clog2(LANES+1)-1:0]   o_pos_count,
  output logic [CNT_W-1:0]             beat_count
);

  localparam int unsigned PC_W = $clog2(LANES + 1);

  logic                 s1_valid;
  mode_e                s1_mode;
  logic [WIDTH-1:0]     s1_u  [LANES];
  logic [WIDTH-1:0]     s1_m2 [LANES];

  logic [WIDTH-1:0]     in_u  [LANES];
  logic [WIDTH-1:0]     in_m2 [LANES];
  logic [WIDTH-1:0]     lane_o [LANES];
  logic [LANES-1:0]     lane_pos;
  logic [LANES*WIDTH-1:0] o_next;
  logic [PC_W-1:0]      pos_sum;

  logic s1_adv;
  logic s2_adv;
  logic in_xfer;

  // Handshake: out_valid is the stage-2 valid flag itself.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && s1_adv;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int unsigned E_LSB  = lane_lsb(gi, WIDTH);
    localparam int unsigned M1_LSB = mask1_lsb(gi, WIDTH);
    localparam int unsigned M2_LSB = mask2_lsb(gi, WIDTH);

    assign in_u[gi]  = e_input[E_LSB +: WIDTH] + g_input[M1_LSB +: WIDTH];
    assign in_m2[gi] = g_input[M2_LSB +: WIDTH];

    masked_act_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .u     (s1_u[gi]),
      .mask2 (s1_m2[gi]),
      .mode  (s1_mode),
      .o_c   (lane_o[gi]),
      .pos_c (lane_pos[gi])
    );
  end

  // Repack lane results and count positive lanes for stage 2.
  always_comb begin
    o_next  = '0;
    pos_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_next[i*WIDTH +: WIDTH] = lane_o[i];
      pos_sum = pos_sum + PC_W'(lane_pos[i]);
    end
  end

  // Stage 1: unmasked value, output mask and mode travel together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_SIGN;
      for (int i = 0; i < LANES; i++) begin
        s1_u[i]  <= '0;
        s1_m2[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode_e'(mode);
        for (int i = 0; i < LANES; i++) begin
          s1_u[i]  <= in_u[i];
          s1_m2[i] <= in_m2[i];
        end
      end
    end
  end

  // Stage 2: registered outputs, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      o           <= '0;
      o_pos_count <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        o           <= o_next;
        o_pos_count <= pos_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (in_xfer) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_masked_act_pipe.sv
// Directed bench for masked_act_pipe with hand-computed lane results and an
// in-order expected-output queue.
module tb_masked_act_pipe;

  localparam int unsigned W = 64;
  localparam int unsigned L = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           mode = 1'b0;
  logic [L*W-1:0] e_input = '0;
  logic [2*L*W-1:0] g_input = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] o;
  logic [2:0]     o_pos_count;
  logic [31:0]    beat_count;

  masked_act_pipe #(.WIDTH(W), .LANES(L), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .e_input     (e_input),
    .g_input     (g_input),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o           (o),
    .o_pos_count (o_pos_count),
    .beat_count  (beat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [L*W-1:0] exp_o_q [$];
  logic [2:0]     exp_pc_q [$];
  logic [L*W-1:0] cur_o;
  logic [2:0]     cur_pc;
  logic [L*W-1:0] held_o;
  logic           held_vld = 1'b0;
  logic           acc;
  int             n_acc = 0;
  int             n_out = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [L*W-1:0] pack4(input logic [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [2*L*W-1:0] gpack(input logic [63:0] a1, a2, b1, b2,
                                             c1, c2, d1, d2);
    return {d2, d1, c2, c1, b2, b1, a2, a1};
  endfunction

  task automatic drive(input logic v, input logic m, input logic [L*W-1:0] e,
                       input logic [2*L*W-1:0] g, input logic [L*W-1:0] xo,
                       input logic [2:0] xpc);
    in_valid = v;
    mode     = m;
    e_input  = e;
    g_input  = g;
    cur_o    = xo;
    cur_pc   = xpc;
  endtask

  // Sample on the falling edge, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      exp_o_q.push_back(cur_o);
      exp_pc_q.push_back(cur_pc);
      n_acc++;
    end
    if (held_vld) begin
      check("stall_valid", 256'(out_valid), 256'(1));
      check("stall_o", 256'(o), 256'(held_o));
    end
    if (out_valid && out_ready) begin
      if (exp_o_q.size() == 0) begin
        check("unexpected_out", 256'(out_valid), 256'(0));
      end else begin
        check("o", 256'(o), 256'(exp_o_q.pop_front()));
        check("pos_count", 256'(o_pos_count), 256'(exp_pc_q.pop_front()));
        n_out++;
      end
    end
    held_vld = out_valid && !out_ready;
    held_o   = o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    drive(1'b0, 1'b0, '0, '0, '0, 3'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_o_q.size() != 0; i++) step();
    step();
    check(tag, 256'(exp_o_q.size()), 256'(0));
  endtask

  logic [L*W-1:0]   e1, e2, o1s, o1r, o2s, o2r;
  logic [2*L*W-1:0] g1, g2;
  int               k;

  initial begin
    // Lanes: +5 | -3 | 0 with mask2 all-ones | 0x8000.. with mask2 0
    e1  = pack4(64'hFFFFFFFFFFFFFFFB, 64'd0, 64'd0, 64'h8000000000000000);
    g1  = gpack(64'd10, 64'd100, 64'hFFFFFFFFFFFFFFFD, 64'd100,
                64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0);
    o1s = pack4(64'd101, 64'd99, 64'd0, 64'hFFFFFFFFFFFFFFFF);
    o1r = pack4(64'd105, 64'd100, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    // Lanes: u=2 | u=-7 | u=7 | u=0x7FFF..
    e2  = pack4(64'd1, 64'hFFFFFFFFFFFFFFF6, 64'd3, 64'h7FFFFFFFFFFFFFFF);
    g2  = gpack(64'd1, 64'd7, 64'd3, 64'd20, 64'd4, 64'd5, 64'd0, 64'd1);
    o2s = pack4(64'd8, 64'd19, 64'd6, 64'd2);
    o2r = pack4(64'd9, 64'd20, 64'd12, 64'h8000000000000000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_o", 256'(o), 256'(0));
    check("rst_pos_count", 256'(o_pos_count), 256'(0));
    check("rst_beat_count", 256'(beat_count), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));

    // Single SIGN beat with latency checks
    out_ready = 1'b1;
    drive(1'b1, 1'b0, e1, g1, o1s, 3'd2);
    step();
    check("t1_accept", 256'(acc), 256'(1));
    drive(1'b0, 1'b0, '0, '0, '0, 3'd0);
    check("t1_lat1_valid", 256'(out_valid), 256'(0));
    step();
    check("t1_lat2_valid", 256'(out_valid), 256'(1));
    drain("t1_drain");

    // Same vector in RELU
    drive(1'b1, 1'b1, e1, g1, o1r, 3'd2);
    step();
    drive(1'b0, 1'b0, '0, '0, '0, 3'd0);
    step();
    check("t2_valid", 256'(out_valid), 256'(1));
    drain("t2_drain");

    // Back-to-back beats with alternating mode
    drive(1'b1, 1'b0, e1, g1, o1s, 3'd2); step();
    drive(1'b1, 1'b1, e2, g2, o2r, 3'd3); step();
    drive(1'b1, 1'b1, e1, g1, o1r, 3'd2); step();
    drive(1'b1, 1'b0, e2, g2, o2s, 3'd3); step();
    drain("alt_drain");
    check("alt_beat_count", 256'(beat_count), 256'(n_acc));

    // Backpressure: out_ready low for the first 3 cycles of a continuous stream
    k = 10;
    for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
      out_ready = (cyc >= 3);
      drive(1'b1, 1'b1, pack4(64'(k), 64'd0, 64'd0, 64'd0), '0,
            pack4(64'(k), 64'd0, 64'd0, 64'd0), 3'd4);
      step();
      if (cyc == 2) check("bp_in_ready_low", 256'(acc), 256'(0));
      if (cyc == 2) check("bp_accepts_before_stall", 256'(k), 256'(12));
      if (acc) k++;
    end
    check("bp_all_sent", 256'(k), 256'(16));
    drain("bp_drain");
    check("bp_beat_count", 256'(beat_count), 256'(n_acc));
    check("out_once", 256'(n_out), 256'(n_acc));

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(1'b1, 1'b0, e1, g1, o1s, 3'd2); step();
    drive(1'b1, 1'b1, e2, g2, o2r, 3'd3); step();
    drive(1'b0, 1'b0, '0, '0, '0, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 256'(out_valid), 256'(0));
    check("async_rst_beat_count", 256'(beat_count), 256'(0));
    exp_o_q.delete();
    exp_pc_q.delete();
    held_vld = 1'b0;
    n_acc = 0;
    n_out = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_stale", 256'(out_valid), 256'(0));
    end
    drive(1'b1, 1'b0, e2, g2, o2s, 3'd3); step();
    drain("post_rst_drain");
    check("post_rst_beat_count", 256'(beat_count), 256'(1));
    check("post_rst_out_once", 256'(n_out), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
